mem_arbiter_ctrl: RTL and testbench
===================================

Name: mem_arbiter_ctrl

Overview:
- Single-port memory arbiter and sequencer between the instruction-fetch requester (icuREN path) and the data requester (dcuREN/dcuWEN path) of one core.
- Serialises both onto one RAM port and holds the requester's wait line until the RAM acknowledges.
- Grants data first, with alternating fairness so instruction fetch cannot starve.
- Times out stuck accesses and flags an error.

Parameters:
- WORD_W, 32, data/address width (matches word_t)
- TIMEOUT, 15, max cycles in an access state before abort; must be >= 1
- ERR_WORD, 32'hBAD1BAD1, value returned on a timed-out read

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-high
- iREN  in  1  instruction read request
- iaddr  in  WORD_W  instruction address
- iwait  out  1  high while the instruction request is not being completed this cycle
- iload  out  WORD_W  instruction data, valid when iREN && !iwait
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins over dREN if both are high
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  write data
- dwait  out  1  high while the data request is not being completed this cycle
- dload  out  WORD_W  read data, valid when dREN && !dwait
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address (registered)
- ramstore  out  WORD_W  RAM write data (registered)
- ramload  in  WORD_W  RAM read data
- ram_ready  in  1  RAM completion: read data valid, or write accepted
- err  out  1  sticky timeout flag

Behaviour:
- Interface: one clock CLK; RST is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - iwait = dwait = 1
  - ramREN = ramWEN = 0
  - ramaddr = ramstore = 0
  - iload = dload = 0
  - err = 0
  - last_d = 0
  - timeout counter = 0
- States: IDLE, DACC, IACC.
- IDLE:
  - Data request pending (dREN|dWEN) and (!last_d or !iREN) -> DACC.
  - Else iREN -> IACC.
  - Else stay in IDLE.
- Net effect of the grant rule: data has priority, but after a data grant a waiting fetch is served next.
- On grant (IDLE -> xACC edge):
  - Latch ramaddr, plus ramstore for writes.
  - Latch operation type; write if dWEN.
  - Clear the counter.
  - last_d <= (grant == data).
- xACC, RAM strobe: assert ramREN or ramWEN per the latched operation. Strobes are registered and drop to 0 on exit to IDLE.
- xACC, ram_ready = 1:
  - Same cycle, drive the granted requester's wait = 0.
  - Pass ramload combinationally to iload/dload (reads only).
  - Next state IDLE.
  - Minimum latency request -> completion is 2 cycles: grant cycle + 1 access cycle with ready.
- xACC, ram_ready = 0: counter++. When the counter == TIMEOUT:
  - Abort: wait = 0 for that requester, load = ERR_WORD.
  - Set err = 1; err is sticky until RST.
  - Next state IDLE.
- No back-to-back grant: IDLE is always visited for 1 cycle between accesses.
- Requester wait lines: the non-granted requester's wait stays 1 throughout.
- Requester deasserts its request mid-access: the access still completes on the latched address/data; the wait pulse is ignored.
- Address or data changes mid-access: ignored, because values were latched at grant.
- RST mid-access: immediate return to reset values. The in-flight RAM op is abandoned and no completion is reported.
- load outputs are 0 whenever the corresponding wait = 1.

Decomposition:
- Shared package mem_arb_pkg, containing:
  - arb_state_t enum {IDLE, DACC, IACC}
  - ERR_WORD constant
  - word_t, imported from cpu_types_pkg
- One natural sub-module, arb_timeout_ctr: load/clear, increment, and terminal-count compare against TIMEOUT.

Test Plan:
- Instruction fetch: iREN=1, iaddr=0x40, ram_ready high on the 2nd cycle with ramload=0x8C220004 -> ramREN=1 and ramaddr=0x40; iwait=0 and iload=0x8C220004 in exactly the ready cycle; IDLE next cycle.
- Data priority: iREN and dREN high together from IDLE (last_d=0) -> DACC first; IACC next after one IDLE cycle; dwait drops before iwait.
- Fairness: dREN held continuously and iREN held; ready on every access -> grants alternate D, I, D, I; iwait falls within 6 cycles.
- Write over read: dWEN=dREN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 on ready.
- Timeout: dREN with ram_ready held 0, TIMEOUT=15 -> dwait=0 and dload=0xBAD1BAD1 in the 16th DACC cycle; err=1 and stays 1 through subsequent good accesses.
- Async reset mid-access: assert RST between clock edges during IACC -> outputs take reset values immediately (iwait=1, ramREN=0, err=0); no completion pulse after release.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Core-wide basic types shared by the CPU blocks.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
endpackage

// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;
  typedef cpu_types_pkg::word_t word_t;

  typedef enum logic [1:0] {IDLE, DACC, IACC} arb_state_t;

  localparam word_t ERR_WORD = 32'hBAD1BAD1;
endpackage

// File: rtl/arb_timeout_ctr.sv
// Access-age counter: cleared while idle, counts stalled access cycles, flags TIMEOUT reached.
module arb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tc_o = (cnt_q == CntW'(TIMEOUT));
endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Serialises instruction fetch and data accesses onto one RAM port, data-first with
// alternating fairness, and aborts accesses the RAM never acknowledges.
module mem_arbiter_ctrl
  import mem_arb_pkg::*;
#(
  parameter int unsigned        WORD_W   = 32,
  parameter int unsigned        TIMEOUT  = 15,
  parameter logic [WORD_W-1:0]  ERR_WORD = mem_arb_pkg::ERR_WORD
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err
);
  arb_state_t state;
  logic       op_wr;
  logic       last_d;
  logic       tc;
  logic       in_acc;
  logic       done;
  logic       d_req;

  assign d_req  = dREN | dWEN;
  assign in_acc = (state != IDLE);
  // An access ends on RAM acknowledge or when the stall counter hits its limit.
  assign done   = in_acc && (ram_ready || tc);

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout_ctr (
    .clk_i(CLK),
    .rst_i(RST),
    .clr_i(state == IDLE),
    .inc_i(in_acc && !ram_ready && !tc),
    .tc_o (tc)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      op_wr    <= 1'b0;
      last_d   <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A fetch waiting behind a data grant goes next.
          if (d_req && (!last_d || !iREN)) begin
            state   <= DACC;
            ramaddr <= daddr;
            op_wr   <= dWEN;
            ramWEN  <= dWEN;
            ramREN  <= !dWEN;
            last_d  <= 1'b1;
            if (dWEN) begin
              ramstore <= dstore;
            end
          end else if (iREN) begin
            state   <= IACC;
            ramaddr <= iaddr;
            op_wr   <= 1'b0;
            ramWEN  <= 1'b0;
            ramREN  <= 1'b1;
            last_d  <= 1'b0;
          end
        end
        DACC, IACC: begin
          if (done) begin
            state  <= IDLE;
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            if (!ram_ready) begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait = 1'b1;
    dwait = 1'b1;
    iload = '0;
    dload = '0;
    if (done) begin
      if (state == DACC) begin
        dwait = 1'b0;
        if (!op_wr) begin
          dload = ram_ready ? ramload : ERR_WORD;
        end
      end else begin
        iwait = 1'b0;
        iload = ram_ready ? ramload : ERR_WORD;
      end
    end
  end
endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios plus randomized traffic
// against a transaction-level ownership model.
module tb_mem_arbiter_ctrl;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned TIMEOUT = 15;
  localparam logic [31:0] ERRW    = 32'hBAD1BAD1;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks   = 0;
  int failures = 0;

  mem_arbiter_ctrl #(
    .WORD_W  (WORD_W),
    .TIMEOUT (TIMEOUT),
    .ERR_WORD(ERRW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ram_ready(ram_ready),
    .err      (err)
  );

  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] ds, input logic rdy,
                       input logic [31:0] rl);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    ram_ready = rdy; ramload = rl;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h30, 1'b1, 32'h40);
    #12;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=11000", {iwait, dwait, ramREN, ramWEN, err});
    end
    checks++;
    if ({ramaddr, ramstore, iload, dload} !== 128'h0) begin
      failures++;
      $display("FAIL reset_data got=%h exp=0", {ramaddr, ramstore, iload, dload});
    end
    next_cycle();
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_ifetch();
    next_cycle();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      failures++;
      $display("FAIL ifetch_req got=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
    end
    next_cycle();
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8C220004);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramaddr, iload} !== {4'b0110, 32'h40, 32'h8C220004}) begin
      failures++;
      $display("FAIL ifetch_ready got=%b %h %h exp=0110 00000040 8c220004",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, iload);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, ramREN, iload} !== {2'b10, 32'h0}) begin
      failures++;
      $display("FAIL ifetch_idle got=%b %h exp=10 0", {iwait, ramREN}, iload);
    end
  endtask

  task automatic test_priority();
    next_cycle();
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      failures++;
      $display("FAIL prio_req got=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
    end
    next_cycle();
    drive(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h11111111);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramaddr, dload} !== {4'b1010, 32'h200, 32'h11111111}) begin
      failures++;
      $display("FAIL prio_data_first got=%b %h %h exp=1010 00000200 11111111",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, dload);
    end
    next_cycle();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      failures++;
      $display("FAIL prio_gap got=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
    end
    next_cycle();
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h22222222);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramaddr, iload} !== {4'b0110, 32'h80, 32'h22222222}) begin
      failures++;
      $display("FAIL prio_fetch_second got=%b %h %h exp=0110 00000080 22222222",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, iload);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_fairness();
    int first_i;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_addr;
    first_i = -1;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      drive(1'b1, 32'h400, 1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'hA0 + k);
      #3;
      // Even cycles are the mandatory idle gap; odd ones alternate data, fetch.
      if (k % 2 == 0) begin
        exp_ctrl = 4'b1100;
        exp_addr = ramaddr;
      end else if (k % 4 == 1) begin
        exp_ctrl = 4'b1010;
        exp_addr = 32'h300;
      end else begin
        exp_ctrl = 4'b0110;
        exp_addr = 32'h400;
      end
      checks++;
      if ({iwait, dwait, ramREN, ramWEN, ramaddr} !== {exp_ctrl, exp_addr}) begin
        failures++;
        $display("FAIL fair_cycle%0d got=%b %h exp=%b %h", k,
                 {iwait, dwait, ramREN, ramWEN}, ramaddr, exp_ctrl, exp_addr);
      end
      if (first_i < 0 && iwait == 1'b0) first_i = k;
    end
    checks++;
    if (first_i < 0 || first_i > 6) begin
      failures++;
      $display("FAIL fair_fetch_latency got=%0d exp=<=6", first_i);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_write();
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0);
    next_cycle();
    // Address and data change mid-access; the latched values must be used.
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramaddr, ramstore} !==
        {4'b1101, 32'h100, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL write_strobe got=%b %h %h exp=1101 00000100 deadbeef",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, 32'h0, 1'b1, 32'h55555555);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, ramstore} !== {4'b1001, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL write_ready got=%b %h exp=1001 deadbeef",
               {iwait, dwait, ramREN, ramWEN}, ramstore);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      failures++;
      $display("FAIL write_exit got=%b exp=1100", {iwait, dwait, ramREN, ramWEN});
    end
  endtask

  task automatic test_timeout();
    logic [4:0]  exp_ctrl;
    logic [31:0] exp_load;
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h12345678);
    for (int k = 1; k <= TIMEOUT + 1; k++) begin
      next_cycle();
      #3;
      exp_ctrl = (k == TIMEOUT + 1) ? 5'b10100 : 5'b11100;
      exp_load = (k == TIMEOUT + 1) ? ERRW : 32'h0;
      checks++;
      if ({iwait, dwait, ramREN, ramWEN, err, dload} !== {exp_ctrl, exp_load}) begin
        failures++;
        $display("FAIL timeout_cycle%0d got=%b %h exp=%b %h", k,
                 {iwait, dwait, ramREN, ramWEN, err}, dload, exp_ctrl, exp_load);
      end
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, err} !== 5'b11001) begin
      failures++;
      $display("FAIL timeout_err_set got=%b exp=11001", {iwait, dwait, ramREN, ramWEN, err});
    end
    next_cycle();
    drive(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    drive(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77);
    #3;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, err, iload} !== {5'b01101, 32'h77}) begin
      failures++;
      $display("FAIL timeout_err_sticky got=%b %h exp=01101 00000077",
               {iwait, dwait, ramREN, ramWEN, err}, iload);
    end
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic test_async_reset();
    next_cycle();
    drive(1'b1, 32'h90, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    #3;
    checks++;
    if ({iwait, ramREN, ramaddr} !== {2'b11, 32'h90}) begin
      failures++;
      $display("FAIL arst_pre got=%b %h exp=11 00000090", {iwait, ramREN}, ramaddr);
    end
    #2;
    RST = 1'b1;
    #1;
    checks++;
    if ({iwait, dwait, ramREN, ramWEN, err, ramaddr, iload} !== {5'b11000, 64'h0}) begin
      failures++;
      $display("FAIL arst_immediate got=%b %h %h exp=11000 0 0",
               {iwait, dwait, ramREN, ramWEN, err}, ramaddr, iload);
    end
    next_cycle();
    RST = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h99);
    for (int k = 0; k < 3; k++) begin
      #3;
      checks++;
      if ({iwait, dwait, ramREN, ramWEN, iload} !== {4'b1100, 32'h0}) begin
        failures++;
        $display("FAIL arst_no_completion%0d got=%b %h exp=1100 0", k,
                 {iwait, dwait, ramREN, ramWEN}, iload);
      end
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Reference model: who owns the RAM, how many cycles that access has run, what was latched.
  task automatic test_random();
    int          owner;          // 0 = nobody, 1 = data requester, 2 = fetch requester
    int          age;
    logic        m_wr, m_last_data, m_err, fin, stall;
    logic [31:0] m_addr, m_store, exp_i, exp_d;
    logic [132:0] exp_v, got_v;
    owner = 0; age = 0; m_wr = 1'b0; m_last_data = 1'b0; m_err = 1'b0;
    m_addr = 32'h0; m_store = 32'h0; stall = 1'b0;
    RST = 1'b1;
    #3;
    next_cycle();
    RST = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      next_cycle();
      if ($urandom_range(0, 39) == 0) stall = !stall;
      drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) == 0, $urandom, $urandom,
            stall ? 1'b0 : ($urandom_range(0, 2) != 0), $urandom);
      #3;
      fin   = (owner != 0) && (ram_ready || age == TIMEOUT);
      exp_i = (fin && owner == 2) ? (ram_ready ? ramload : ERRW) : 32'h0;
      exp_d = (fin && owner == 1 && !m_wr) ? (ram_ready ? ramload : ERRW) : 32'h0;
      exp_v = {!(fin && owner == 2), !(fin && owner == 1), (owner != 0) && !m_wr,
               (owner != 0) && m_wr, m_err, exp_i, exp_d, m_addr, m_store};
      got_v = {iwait, dwait, ramREN, ramWEN, err, iload, dload, ramaddr, ramstore};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL random_cycle%0d got=%h exp=%h", n, got_v, exp_v);
      end
      if (owner == 0) begin
        if ((dREN || dWEN) && !(m_last_data && iREN)) begin
          owner = 1; m_wr = dWEN; m_addr = daddr; m_last_data = 1'b1; age = 0;
          if (dWEN) m_store = dstore;
        end else if (iREN) begin
          owner = 2; m_wr = 1'b0; m_addr = iaddr; m_last_data = 1'b0; age = 0;
        end
      end else if (fin) begin
        if (!ram_ready) m_err = 1'b1;
        owner = 0;
      end else begin
        age++;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    test_reset();
    test_ifetch();
    test_priority();
    test_fairness();
    test_write();
    test_timeout();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
